// File: rtl/sa_a_feeder_pkg.sv
// Shared definitions for the systolic-array A-matrix feeder.
// Holds the FSM encoding, matrix size and the skewed wavefront count.
package sa_a_feeder_pkg;

  localparam int N         = 4;
  localparam int NUM_WAVES = 2 * N - 1;
  localparam int WAVE_W    = 3;
  localparam int CNT_W     = 16;

  typedef enum logic [2:0] {
    IDLE,
    FEED,
    DRAIN,
    LOAD,
    DONE
  } state_t;

endpackage

// File: rtl/sa_skew_counter.sv
// Step counter plus wavefront index for the A feeder.
// Exposes the next wavefront value so the feeder can register its outputs.
module sa_skew_counter
  import sa_a_feeder_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              en,
  input  logic [CNT_W-1:0]  step_len,
  output logic              step_done,
  output logic              wave_done,
  output logic [WAVE_W-1:0] wave_nxt
);

  logic [CNT_W-1:0]  step_cnt;
  logic [CNT_W-1:0]  step_d;
  logic [WAVE_W-1:0] wave_cnt;
  logic [WAVE_W-1:0] wave_d;

  assign step_done = (step_cnt == step_len - CNT_W'(1));
  assign wave_done = step_done && (wave_cnt == WAVE_W'(NUM_WAVES - 1));
  assign wave_nxt  = wave_d;

  always_comb begin
    step_d = step_cnt;
    wave_d = wave_cnt;
    if (clear) begin
      step_d = '0;
      wave_d = '0;
    end else if (en) begin
      if (step_done) begin
        step_d = '0;
        wave_d = (wave_cnt == WAVE_W'(NUM_WAVES - 1)) ? '0 : wave_cnt + WAVE_W'(1);
      end else begin
        step_d = step_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step_cnt <= '0;
      wave_cnt <= '0;
    end else begin
      step_cnt <= step_d;
      wave_cnt <= wave_d;
    end
  end

endmodule

// File: rtl/sa_a_feeder.sv
// Buffers a 4x4 A matrix and streams it into the systolic array as skewed
// wavefronts, then drains, pulses result_ld and signals done.
module sa_a_feeder
  import sa_a_feeder_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int STEP         = 2,
  parameter int DRAIN_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [1:0]            wr_row,
  input  logic [1:0]            wr_col,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  start,
  output logic [DATA_WIDTH-1:0] FDo0,
  output logic [DATA_WIDTH-1:0] FDo4,
  output logic [DATA_WIDTH-1:0] FDo8,
  output logic [DATA_WIDTH-1:0] FDo12,
  output logic                  feed_valid,
  output logic                  result_ld,
  output logic                  busy,
  output logic                  done
);

  state_t state;
  state_t state_next;

  logic [DATA_WIDTH-1:0] a_mem [N][N];
  logic [DATA_WIDTH-1:0] a_nxt [N][N];
  logic [DATA_WIDTH-1:0] fdo   [N];
  logic [DATA_WIDTH-1:0] fdo_d [N];

  logic              cnt_clear;
  logic              cnt_en;
  logic [CNT_W-1:0]  step_len;
  logic              step_done;
  logic              wave_done;
  logic [WAVE_W-1:0] wave_nxt;
  int                col;

  sa_skew_counter u_counter (
    .clk       (clk),
    .rst       (rst),
    .clear     (cnt_clear),
    .en        (cnt_en),
    .step_len  (step_len),
    .step_done (step_done),
    .wave_done (wave_done),
    .wave_nxt  (wave_nxt)
  );

  assign cnt_clear = (state_next != state);
  assign cnt_en    = (state == FEED) || (state == DRAIN) || (state == LOAD);
  assign step_len  = (state == DRAIN) ? CNT_W'(DRAIN_CYCLES) : CNT_W'(STEP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // With no drain cycles configured the DRAIN state is skipped entirely.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = FEED;
      FEED:    if (wave_done) state_next = (DRAIN_CYCLES > 0) ? DRAIN : LOAD;
      DRAIN:   if (step_done) state_next = LOAD;
      LOAD:    if (step_done) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    a_nxt = a_mem;
    if (state == IDLE && wr_en) a_nxt[wr_row][wr_col] = wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++)
          a_mem[r][c] <= '0;
    end else begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++)
          a_mem[r][c] <= a_nxt[r][c];
    end
  end

  // Outputs are computed from next-cycle state and the post-write buffer,
  // so a write sampled with start is already visible in the first wavefront.
  always_comb begin
    col = 0;
    for (int r = 0; r < N; r++) begin
      fdo_d[r] = '0;
      col = int'(wave_nxt) - r;
      if (state_next == FEED && col >= 0 && col < N) fdo_d[r] = a_nxt[r][col[1:0]];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < N; r++) fdo[r] <= '0;
    end else begin
      for (int r = 0; r < N; r++) fdo[r] <= fdo_d[r];
    end
  end

  assign FDo0       = fdo[0];
  assign FDo4       = fdo[1];
  assign FDo8       = fdo[2];
  assign FDo12      = fdo[3];
  assign feed_valid = (state == FEED);
  assign result_ld  = (state == LOAD);
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);

endmodule

// File: tb/tb_sa_a_feeder.sv
// Scoreboard bench for sa_a_feeder: two instances (default timing and
// STEP=1/DRAIN_CYCLES=0) compared cycle by cycle against a timeline model.
module tb_sa_a_feeder;

  localparam int DW = 16;
  localparam int S0 = 2;
  localparam int D0 = 8;
  localparam int S1 = 1;
  localparam int D1 = 0;

  typedef struct packed {
    logic [DW-1:0] f0;
    logic [DW-1:0] f1;
    logic [DW-1:0] f2;
    logic [DW-1:0] f3;
    logic          fv;
    logic          rl;
    logic          bz;
    logic          dn;
  } obs_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en   [2];
  logic [1:0]    wr_row  [2];
  logic [1:0]    wr_col  [2];
  logic [DW-1:0] wr_data [2];
  logic          start   [2];
  logic [DW-1:0] fdo0 [2];
  logic [DW-1:0] fdo4 [2];
  logic [DW-1:0] fdo8 [2];
  logic [DW-1:0] fdo12 [2];
  logic          feed_valid [2];
  logic          result_ld  [2];
  logic          busy       [2];
  logic          done       [2];

  int   model_a [2][4][4];
  int   pos     [2];
  obs_t exp_q0 [$];
  obs_t exp_q1 [$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sa_a_feeder #(.DATA_WIDTH(DW), .STEP(S0), .DRAIN_CYCLES(D0)) dut0 (
    .clk(clk), .rst(rst),
    .wr_en(wr_en[0]), .wr_row(wr_row[0]), .wr_col(wr_col[0]), .wr_data(wr_data[0]),
    .start(start[0]),
    .FDo0(fdo0[0]), .FDo4(fdo4[0]), .FDo8(fdo8[0]), .FDo12(fdo12[0]),
    .feed_valid(feed_valid[0]), .result_ld(result_ld[0]), .busy(busy[0]), .done(done[0])
  );

  sa_a_feeder #(.DATA_WIDTH(DW), .STEP(S1), .DRAIN_CYCLES(D1)) dut1 (
    .clk(clk), .rst(rst),
    .wr_en(wr_en[1]), .wr_row(wr_row[1]), .wr_col(wr_col[1]), .wr_data(wr_data[1]),
    .start(start[1]),
    .FDo0(fdo0[1]), .FDo4(fdo4[1]), .FDo8(fdo8[1]), .FDo12(fdo12[1]),
    .feed_valid(feed_valid[1]), .result_ld(result_ld[1]), .busy(busy[1]), .done(done[1])
  );

  function automatic int step_of(input int idx);
    return (idx == 0) ? S0 : S1;
  endfunction

  function automatic int drain_of(input int idx);
    return (idx == 0) ? D0 : D1;
  endfunction

  function automatic obs_t actual(input int idx);
    obs_t o;
    o.f0 = fdo0[idx];
    o.f1 = fdo4[idx];
    o.f2 = fdo8[idx];
    o.f3 = fdo12[idx];
    o.fv = feed_valid[idx];
    o.rl = result_ld[idx];
    o.bz = busy[idx];
    o.dn = done[idx];
    return o;
  endfunction

  // Position p counts cycles since the start edge: 7*S feed cycles, D drain,
  // S load cycles and one done cycle; p = 0 means idle.
  function automatic obs_t model_obs(input int idx);
    obs_t          o;
    logic [DW-1:0] f [4];
    int            s;
    int            d;
    int            p;
    int            t;
    int            c;
    o = '0;
    s = step_of(idx);
    d = drain_of(idx);
    p = pos[idx];
    for (int r = 0; r < 4; r++) f[r] = '0;
    if (p != 0) begin
      o.bz = 1'b1;
      if (p <= 7 * s) begin
        o.fv = 1'b1;
        t = (p - 1) / s;
        for (int r = 0; r < 4; r++) begin
          c = t - r;
          if (c >= 0 && c < 4) f[r] = DW'(model_a[idx][r][c]);
        end
      end
      o.rl = (p > 7 * s + d) && (p <= 8 * s + d);
      o.dn = (p == 8 * s + d + 1);
    end
    o.f0 = f[0];
    o.f1 = f[1];
    o.f2 = f[2];
    o.f3 = f[3];
    return o;
  endfunction

  task automatic checkOutput(input int idx, input obs_t exp, input string name);
    obs_t act;
    act = actual(idx);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s dut%0d t=%0t: got %h expected %h", name, idx, $time, act, exp);
    end
  endtask

  task automatic model_step(input int idx);
    int len;
    len = 8 * step_of(idx) + drain_of(idx) + 1;
    if (!rst) begin
      pos[idx] = 0;
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          model_a[idx][r][c] = 0;
    end else if (pos[idx] == 0) begin
      if (wr_en[idx]) model_a[idx][wr_row[idx]][wr_col[idx]] = int'(wr_data[idx]);
      if (start[idx]) pos[idx] = 1;
    end else begin
      pos[idx] = pos[idx] + 1;
      if (pos[idx] > len) pos[idx] = 0;
    end
    if (idx == 0) exp_q0.push_back(model_obs(0));
    else          exp_q1.push_back(model_obs(1));
  endtask

  task automatic applyStimulus(input int idx, input logic we, input int row, input int col,
                               input int data, input logic st);
    wr_en[idx]   = we;
    wr_row[idx]  = 2'(row);
    wr_col[idx]  = 2'(col);
    wr_data[idx] = DW'(data);
    start[idx]   = st;
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < 2; i++) applyStimulus(i, 1'b0, 0, 0, 0, 1'b0);
  endtask

  task automatic tick();
    model_step(0);
    model_step(1);
    @(negedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic start_both();
    for (int i = 0; i < 2; i++) applyStimulus(i, 1'b0, 0, 0, 0, 1'b1);
    tick();
  endtask

  // Monitor: one expectation per clock edge, compared mid-cycle.
  initial begin
    obs_t exp;
    forever begin
      @(negedge clk);
      exp = (exp_q0.size() > 0) ? exp_q0.pop_front() : '0;
      checkOutput(0, exp, "trace");
      exp = (exp_q1.size() > 0) ? exp_q1.pop_front() : '0;
      checkOutput(1, exp, "trace");
    end
  end

  initial begin
    rst = 1'b0;
    pos[0] = 0;
    pos[1] = 0;
    for (int i = 0; i < 2; i++)
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          model_a[i][r][c] = 0;
    clear_inputs();
    @(negedge clk);
    #1;
    run(3);
    rst = 1'b1;
    run(2);

    // Load A[r][c] = 4r+c+1 and run a full sequence.
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        for (int i = 0; i < 2; i++) applyStimulus(i, 1'b1, r, c, 4 * r + c + 1, 1'b0);
        tick();
      end
    start_both();
    run(30);

    // Write sampled on the same edge as start is part of the sequence.
    for (int i = 0; i < 2; i++) applyStimulus(i, 1'b1, 2, 1, 'h00AA, 1'b1);
    tick();
    run(30);

    // Write and start while feeding are ignored; a rerun shows the old value.
    start_both();
    run(2);
    for (int i = 0; i < 2; i++) applyStimulus(i, 1'b1, 0, 0, 'hFFFF, 1'b1);
    tick();
    run(30);
    start_both();
    run(30);

    // Random writes and starts at any point in the sequence.
    for (int k = 0; k < 200; k++) begin
      for (int i = 0; i < 2; i++)
        applyStimulus(i, $urandom_range(0, 2) == 0, int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 65535)),
                      $urandom_range(0, 9) == 0);
      tick();
    end
    run(30);

    // Reset during wavefront 4 of the default instance.
    start_both();
    for (int k = 0; k < 20 && pos[0] != 9; k++) tick();
    #1;
    rst = 1'b0;
    #1;
    exp_q0.delete();
    exp_q1.delete();
    for (int i = 0; i < 2; i++) begin
      pos[i] = 0;
      checkOutput(i, '0, "reset_immediate");
    end
    run(2);
    rst = 1'b1;
    run(2);
    start_both();
    run(30);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sa_a_feeder.md
SA_A_FEEDER -- requirements
Module: sa_a_feeder

Interface
REQ-001 Parameter DATA_WIDTH, default 16, element width of matrix A.
REQ-002 Parameter STEP, default 2, clock cycles each skewed wavefront is held.
REQ-003 Parameter DRAIN_CYCLES, default 8, zero-fill cycles after the last wavefront before results are loaded.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 wr_en  input  1  write one element of A into the internal buffer.
REQ-007 wr_row  input  2  row index of the written element.
REQ-008 wr_col  input  2  column index of the written element.
REQ-009 wr_data  input  DATA_WIDTH  element value.
REQ-010 start  input  1  launch one feed sequence.
REQ-011 FDo0, FDo4, FDo8, FDo12  output  DATA_WIDTH each  skewed row streams for rows 0..3, wired to the array's FDi0/FDi4/FDi8/FDi12.
REQ-012 feed_valid  output  1  high while a wavefront is being presented.
REQ-013 result_ld  output  1  load strobe wired to the array's result_ld.
REQ-014 busy  output  1  sequence in progress.
REQ-015 done  output  1  one-cycle completion pulse.

Function
REQ-016 The buffer SHALL hold 16 elements A[r][c]; wr_en in IDLE writes wr_data to A[wr_row][wr_col] at the clock edge.
REQ-017 The FSM SHALL have states IDLE, FEED, DRAIN, LOAD, DONE.
REQ-018 IDLE->FEED when start is sampled high; start outside IDLE is ignored.
REQ-019 wr_en outside IDLE is ignored; buffer contents are unchanged.
REQ-020 wr_en and start sampled in the same IDLE edge: the write lands and is included in the sequence.
REQ-021 FEED presents wavefronts t = 0..6, each held for exactly STEP cycles; the first wavefront is visible on the outputs immediately after the edge that samples start (latency 1 clock).
REQ-022 During wavefront t, row r output = A[r][t-r] if 0 <= t-r <= 3, else 0.
REQ-023 All FDo outputs are registered and SHALL be 0 outside FEED.
REQ-024 feed_valid is high for exactly 7*STEP cycles in FEED.
REQ-025 FEED->DRAIN after the last STEP cycle of wavefront 6; DRAIN lasts DRAIN_CYCLES cycles.
REQ-026 LOAD asserts result_ld for exactly STEP cycles, then enters DONE.
REQ-027 DONE asserts done for one cycle, then returns to IDLE; a start sampled in that DONE cycle is ignored.
REQ-028 busy is high in FEED, DRAIN, LOAD and DONE; busy length = 7*STEP + DRAIN_CYCLES + STEP + 1 cycles.
REQ-029 The step counter and wavefront counter SHALL wrap to 0 on every state transition.

Reset
REQ-030 rst low SHALL immediately force IDLE and clear both counters and all 16 buffer entries to 0.
REQ-031 While rst is low, FDo0/4/8/12 = 0, feed_valid = 0, result_ld = 0, busy = 0 and done = 0.
REQ-032 Reset asserted mid-sequence aborts it; no done pulse and no result_ld pulse is produced.

Structure
REQ-033 A shared package SHALL hold the FSM state encoding, N = 4 and the wavefront count 2N-1 = 7.
REQ-034 One sub-module, sa_skew_counter (step counter plus wavefront index, with terminal flag), SHALL be instantiated.

Verification
REQ-035 Load A[r][c] = 4r+c+1 (values 1..16), then start -> wavefront 0 is (1,0,0,0), wavefront 1 is (2,5,0,0), wavefront 3 is (4,7,10,13), wavefront 6 is (0,0,0,16); each is held 2 cycles.
REQ-036 Same load with defaults -> feed_valid lasts 14 cycles, result_ld is high for cycles 23-24 after start, done is a single pulse on cycle 25, and busy lasts 25 cycles.
REQ-037 Write A[2][1] = 0x00AA in the same edge as start -> FDo8 = 0x00AA during wavefront 3.
REQ-038 During FEED, write A[0][0] = 0xFFFF and pulse start -> the sequence is unaffected, and a rerun still outputs the old A[0][0].
REQ-039 Assert rst low during wavefront 4 -> all outputs are 0 at once, done and result_ld never pulse, and the buffer reads back as 0 on the next run.
REQ-040 Set STEP = 1 and DRAIN_CYCLES = 0 -> wavefronts change every cycle, result_ld lasts 1 cycle, and busy lasts 9 cycles.
